relay_reg_bank: RTL and testbench

//  Parametrised bank of NREG general registers, successor to the single-register D/B-type cells.

---
 rtl/relay_pkg.sv | 48 ++++
 rtl/relay_settle_timer.sv | 37 +++
 rtl/relay_reg_bank.sv | 153 +++++++++++++++
 tb/tb_relay_reg_bank.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared types and the one-hot classifier used by the relay register bank.
package relay_pkg;

    localparam int unsigned OH_MAX_W   = 32;
    localparam int unsigned OH_IDX_W   = $clog2(OH_MAX_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } relay_state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_BUS = 1'b1
    } ld_src_t;

    typedef enum logic [1:0] {
        OH_NONE = 2'd0,
        OH_ONE  = 2'd1,
        OH_MANY = 2'd2
    } onehot_kind_t;

    typedef struct packed {
        onehot_kind_t          kind;
        logic [OH_IDX_W-1:0]   idx;
    } onehot_res_t;

    // Classifies a strobe vector; idx is meaningful only when kind is OH_ONE.
    function automatic onehot_res_t onehot_check(input logic [OH_MAX_W-1:0] vec);
        onehot_res_t res;
        int unsigned ones;
        res  = '{kind: OH_NONE, idx: '0};
        ones = 0;
        for (int i = 0; i < OH_MAX_W; i++) begin
            if (vec[i]) begin
                ones    = ones + 1;
                res.idx = OH_IDX_W'(i);
            end
        end
        if (ones == 1)
            res.kind = OH_ONE;
        else if (ones > 1)
            res.kind = OH_MANY;
        return res;
    endfunction

endpackage

// File: rtl/relay_settle_timer.sv
// Down-counter that models relay settle time; loads SETTLE_CYCLES-1 and stops at zero.
module relay_settle_timer
#(
    parameter int unsigned SETTLE_CYCLES = 2
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic cnt_zero
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        else if (dec && !cnt_zero)
            cnt_d = cnt_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/relay_reg_bank.sv
// Bank of NREG registers with staged, settle-delayed loads and a registered bus read port.
module relay_reg_bank
    import relay_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned NREG          = 4,
    parameter int unsigned SETTLE_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREG-1:0]   ld,
    input  logic              ld_src,
    input  logic [NREG-1:0]   sel,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [WIDTH-1:0]  bus_in,
    output logic [WIDTH-1:0]  bus_out,
    output logic              bus_oe,
    output logic              busy,
    output logic              done,
    output logic              ovr,
    output logic              err,
    output logic [NREG-1:0]   led_ld,
    output logic [NREG-1:0]   led_sel
);

    localparam int unsigned IDX_W = $clog2(NREG);

    relay_state_t       state_q,   state_d;
    logic [WIDTH-1:0]   stage_q,   stage_d;
    logic [IDX_W-1:0]   tgt_q,     tgt_d;
    logic [WIDTH-1:0]   regs_q [NREG];
    logic [WIDTH-1:0]   regs_d [NREG];
    logic [WIDTH-1:0]   bus_out_q, bus_out_d;
    logic               bus_oe_q,  bus_oe_d;
    logic               ovr_q,     ovr_d;
    logic               err_q,     err_d;
    logic [NREG-1:0]    led_sel_q;

    logic               timer_load;
    logic               timer_dec;
    logic               cnt_zero;

    logic [OH_MAX_W-1:0] ld_ext;
    logic [OH_MAX_W-1:0] sel_ext;
    onehot_res_t         ld_chk;
    onehot_res_t         sel_chk;
    logic [IDX_W-1:0]    ld_idx;
    logic [IDX_W-1:0]    sel_idx;

    relay_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .dec      (timer_dec),
        .cnt_zero (cnt_zero)
    );

    always_comb begin
        ld_ext             = '0;
        ld_ext[NREG-1:0]   = ld;
        sel_ext            = '0;
        sel_ext[NREG-1:0]  = sel;
        ld_chk             = onehot_check(ld_ext);
        sel_chk            = onehot_check(sel_ext);
        ld_idx             = ld_chk.idx[IDX_W-1:0];
        sel_idx            = sel_chk.idx[IDX_W-1:0];
    end

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        tgt_d      = tgt_q;
        regs_d     = regs_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        ovr_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ld_chk.kind == OH_ONE) begin
                    stage_d    = (ld_src_t'(ld_src) == SRC_BUS) ? bus_in : alu_result;
                    tgt_d      = ld_idx;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                ovr_d = |ld;
                if (cnt_zero)
                    state_d = COMMIT;
                else
                    timer_dec = 1'b1;
            end
            COMMIT: begin
                ovr_d         = |ld;
                regs_d[tgt_q] = stage_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads see regs_q, so a read in the COMMIT cycle still returns the pre-commit value.
    always_comb begin
        bus_out_d = '0;
        bus_oe_d  = 1'b0;
        if (sel_chk.kind == OH_ONE) begin
            bus_out_d = regs_q[sel_idx];
            bus_oe_d  = 1'b1;
        end
        err_d = (ld_chk.kind == OH_MANY) || (sel_chk.kind == OH_MANY);
    end

    // NOTE: the register array is reset explicitly because a reset must leave every register at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            tgt_q     <= '0;
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
            ovr_q     <= 1'b0;
            err_q     <= 1'b0;
            led_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            tgt_q     <= tgt_d;
            regs_q    <= regs_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            ovr_q     <= ovr_d;
            err_q     <= err_d;
            led_sel_q <= sel;
        end
    end

    assign busy    = (state_q == SETTLE) || (state_q == COMMIT);
    assign done    = (state_q == COMMIT);
    assign led_ld  = busy ? (NREG'(1) << tgt_q) : '0;
    assign led_sel = led_sel_q;
    assign bus_out = bus_out_q;
    assign bus_oe  = bus_oe_q;
    assign ovr     = ovr_q;
    assign err     = err_q;

endmodule

// File: tb/tb_relay_reg_bank.sv
// Directed bench for relay_reg_bank; bus reads are checked through an expected-value queue.
module tb_relay_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ld;
    logic       ld_src;
    logic [3:0] sel;
    logic [7:0] alu_result;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       busy;
    logic       done;
    logic       ovr;
    logic       err;
    logic [3:0] led_ld;
    logic [3:0] led_sel;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [4];
    logic [8:0] exp_q [$];

    relay_reg_bank #(
        .WIDTH         (8),
        .NREG          (4),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld         (ld),
        .ld_src     (ld_src),
        .sel        (sel),
        .alu_result (alu_result),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .busy       (busy),
        .done       (done),
        .ovr        (ovr),
        .err        (err),
        .led_ld     (led_ld),
        .led_sel    (led_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++)
            mdl[i] = 8'h00;
    endtask

    // Drives one cycle of inputs, queues the expected bus read, ticks, then pops and compares it.
    task automatic cyc(input logic [3:0] ld_v, input logic src_v, input logic [3:0] sel_v,
                       input logic [7:0] alu_v, input logic [7:0] bus_v, input string tag);
        logic [8:0] e;
        logic [8:0] got;
        ld         = ld_v;
        ld_src     = src_v;
        sel        = sel_v;
        alu_result = alu_v;
        bus_in     = bus_v;
        e = 9'h000;
        if ($countones(sel_v) == 1) begin
            for (int i = 0; i < 4; i++)
                if (sel_v[i]) e = {1'b1, mdl[i]};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".bus"}, {23'd0, bus_oe, bus_out}, {23'd0, got});
    endtask

    initial begin
        rst_n = 1'b0;
        ld = '0; ld_src = 1'b0; sel = '0; alu_result = '0; bus_in = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.ovr", ovr, 0);
        check("rst.led_ld", led_ld, 0);

        // Read R0 after reset
        cyc(4'b0000, 1'b0, 4'b0001, 8'h00, 8'h00, "rd_r0");
        check("rd_r0.busy", busy, 0);
        check("rd_r0.err", err, 0);

        // Load R1 from ALU with A5; the ALU changes afterwards and must not matter
        cyc(4'b0010, 1'b0, 4'b0000, 8'hA5, 8'h00, "ld1_c0");
        check("ld1_c1.busy", busy, 1);
        check("ld1_c1.led_ld", led_ld, 4'b0010);
        check("ld1_c1.done", done, 0);
        cyc(4'b0000, 1'b0, 4'b0000, 8'hFF, 8'h00, "ld1_c1");
        check("ld1_c2.busy", busy, 1);
        check("ld1_c2.done", done, 0);
        cyc(4'b0000, 1'b0, 4'b0000, 8'hFF, 8'h00, "ld1_c2");
        check("ld1_c3.busy", busy, 1);
        check("ld1_c3.done", done, 1);
        cyc(4'b0000, 1'b0, 4'b0000, 8'hFF, 8'h00, "ld1_c3");
        mdl[1] = 8'hA5;
        check("ld1_c4.busy", busy, 0);
        check("ld1_c4.done", done, 0);
        cyc(4'b0000, 1'b0, 4'b0010, 8'h00, 8'h00, "ld1_rd");
        check("ld1_rd.led_sel", led_sel, 4'b0010);

        // Put 11 into R1 from the bus, then reload 22 from ALU while reading R1 every cycle
        cyc(4'b0010, 1'b1, 4'b0000, 8'h00, 8'h11, "ld11_c0");
        repeat (3) cyc(4'b0000, 1'b0, 4'b0000, 8'h00, 8'h00, "ld11_w");
        mdl[1] = 8'h11;
        cyc(4'b0010, 1'b0, 4'b0010, 8'h22, 8'h00, "ld22_c0");
        cyc(4'b0000, 1'b0, 4'b0010, 8'h00, 8'h00, "ld22_c1");
        cyc(4'b0000, 1'b0, 4'b0010, 8'h00, 8'h00, "ld22_c2");
        check("ld22_c3.done", done, 1);
        cyc(4'b0000, 1'b0, 4'b0010, 8'h00, 8'h00, "ld22_c3");
        mdl[1] = 8'h22;
        cyc(4'b0000, 1'b0, 4'b0010, 8'h00, 8'h00, "ld22_c4");

        // Overrun: R3 load arrives while R2 load is settling
        cyc(4'b0100, 1'b0, 4'b0000, 8'h33, 8'h00, "ovr_c0");
        check("ovr_c1.ovr", ovr, 0);
        cyc(4'b1000, 1'b0, 4'b0000, 8'h44, 8'h00, "ovr_c1");
        check("ovr_c2.ovr", ovr, 1);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00, 8'h00, "ovr_c2");
        check("ovr_c3.ovr", ovr, 0);
        check("ovr_c3.done", done, 1);
        check("ovr_c3.led_ld", led_ld, 4'b0100);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00, 8'h00, "ovr_c3");
        mdl[2] = 8'h33;
        cyc(4'b0000, 1'b0, 4'b1000, 8'h00, 8'h00, "ovr_rd3");
        cyc(4'b0000, 1'b0, 4'b0100, 8'h00, 8'h00, "ovr_rd2");

        // Multi-bit ld and sel raise err and change nothing
        cyc(4'b0110, 1'b0, 4'b0000, 8'h77, 8'h00, "err_ld");
        check("err_ld.err", err, 1);
        check("err_ld.busy", busy, 0);
        cyc(4'b0000, 1'b0, 4'b1001, 8'h00, 8'h00, "err_sel");
        check("err_sel.err", err, 1);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00, 8'h00, "err_idle");
        check("err_idle.err", err, 0);
        cyc(4'b0000, 1'b0, 4'b0100, 8'h00, 8'h00, "err_rd2");
        cyc(4'b0000, 1'b0, 4'b0010, 8'h00, 8'h00, "err_rd1");

        // Reset in cycle 2 of a load into R0 aborts it
        cyc(4'b0001, 1'b0, 4'b0000, 8'h5A, 8'h00, "rl_c0");
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00, 8'h00, "rl_c1");
        rst_n = 1'b0;
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00, 8'h00, "rl_c2");
        rst_n = 1'b1;
        clear_model();
        check("rl_c3.busy", busy, 0);
        check("rl_c3.done", done, 0);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00, 8'h00, "rl_c3");
        check("rl_c4.done", done, 0);
        cyc(4'b0000, 1'b0, 4'b0001, 8'h00, 8'h00, "rl_rd0");
        cyc(4'b0000, 1'b0, 4'b0010, 8'h00, 8'h00, "rl_rd1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
